// File: rtl/test_status_monitor.sv
// Test status monitor: compares retiring PCs against programmable pass/fail watch addresses
// and ends a run on a hit or timeout. Define TESTMON_STALL_EN to add same-PC stall detection.
module test_status_monitor #(
  parameter int XLEN        = 32,
  parameter int NUM_WATCH   = 4,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 16,
  localparam int IDX_W      = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_wen,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [XLEN-1:0]  cfg_addr,
  input  logic             cfg_is_pass,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] timeout_limit,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_valid,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [IDX_W-1:0] hit_idx,
  output logic [CNT_W-1:0] cycle_count
);

  // state   | meaning
  // IDLE    | no run since reset, waiting for start
  // RUN     | run active, watching pc and counting cycles
  // PASS    | pass-entry hit, held until start/reset
  // FAIL    | fail-entry hit (or stall), held until start/reset
  // TIMEOUT | run reached timeout_limit, held until start/reset
  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} state_t;

  if (STALL_LIMIT < 1) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             busy_q, done_q, passed_q, failed_q, timed_out_q;

  logic [XLEN-1:0]      w_addr_q [NUM_WATCH];
  logic [NUM_WATCH-1:0] w_pass_q;
  logic [NUM_WATCH-1:0] w_en_q;

  logic             hit_any;
  logic             hit_pass;
  logic [IDX_W-1:0] hit_sel;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit_any  = 1'b0;
    hit_pass = 1'b0;
    hit_sel  = '0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      if (pc_valid && w_en_q[i] && (pc == w_addr_q[i])) begin
        hit_any  = 1'b1;
        hit_pass = w_pass_q[i];
        hit_sel  = IDX_W'(i);
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef TESTMON_STALL_EN
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  logic [SC_W-1:0] run_len_q, run_len_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            stall_hit;

  always_comb begin
    run_len_d = run_len_q;
    last_pc_d = last_pc_q;
    if (start) begin
      run_len_d = '0;
    end else if (state_q == RUN) begin
      if (pc_valid) begin
        run_len_d = ((run_len_q != '0) && (pc == last_pc_q)) ? run_len_q + 1'b1 : SC_W'(1);
        last_pc_d = pc;
      end else begin
        run_len_d = '0;
      end
    end
  end

  assign stall_hit = (state_q == RUN) && pc_valid && (run_len_d == SC_W'(STALL_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len_q <= '0;
      last_pc_q <= '0;
    end else begin
      run_len_q <= run_len_d;
      last_pc_q <= last_pc_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_idx_d = hit_idx_q;
    if (start) begin
      state_d   = RUN;
      cnt_d     = '0;
      hit_idx_d = '0;
    end else if (state_q == RUN) begin
      if (hit_any) begin
        state_d   = hit_pass ? PASS : FAIL;
        hit_idx_d = hit_sel;
      end else begin
        cnt_d = cnt_inc;
        if ((timeout_limit != '0) && (cnt_inc == timeout_limit)) begin
          state_d = TIMEOUT;
        end
`ifdef TESTMON_STALL_EN
        else if (stall_hit) begin
          state_d   = FAIL;
          hit_idx_d = '1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hit_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_idx_q   <= hit_idx_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
      passed_q    <= (state_d == PASS);
      failed_q    <= (state_d == FAIL);
      timed_out_q <= (state_d == TIMEOUT);
    end
  end

  // Watch table is frozen while a run is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        w_addr_q[i] <= '0;
        w_pass_q[i] <= 1'b0;
        w_en_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (cfg_wen && (state_q != RUN) && (int'(cfg_idx) == i)) begin
          w_addr_q[i] <= cfg_addr;
          w_pass_q[i] <= cfg_is_pass;
          w_en_q[i]   <= cfg_en;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign passed      = passed_q;
  assign failed      = failed_q;
  assign timed_out   = timed_out_q;
  assign hit_idx     = hit_idx_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Testbench for test_status_monitor: directed scenarios plus randomized traffic against a run-level model.
module tb_test_status_monitor;
  localparam int XLEN = 32;
  localparam int NW   = 4;
  localparam int CW   = 10;
  localparam int SL   = 16;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            cfg_wen = 1'b0;
  logic [1:0]      cfg_idx = '0;
  logic [XLEN-1:0] cfg_addr = '0;
  logic            cfg_is_pass = 1'b0;
  logic            cfg_en = 1'b0;
  logic [CW-1:0]   timeout_limit = '0;
  logic [XLEN-1:0] pc = '0;
  logic            pc_valid = 1'b0;
  logic            busy, done, passed, failed, timed_out;
  logic [1:0]      hit_idx;
  logic [CW-1:0]   cycle_count;

  test_status_monitor #(.XLEN(XLEN), .NUM_WATCH(NW), .CNT_W(CW), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_is_pass(cfg_is_pass), .cfg_en(cfg_en),
    .timeout_limit(timeout_limit), .pc(pc), .pc_valid(pc_valid),
    .busy(busy), .done(done), .passed(passed), .failed(failed),
    .timed_out(timed_out), .hit_idx(hit_idx), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Run-level reference: one status value, a cycle tally and the watch table.
  int        m_st;
  int        m_cnt;
  int        m_hit;
  int        m_run;
  logic [XLEN-1:0] m_last;
  logic [XLEN-1:0] m_addr [NW];
  bit        m_pass [NW];
  bit        m_en   [NW];

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_hit = 0; m_run = 0; m_last = '0;
    for (int i = 0; i < NW; i++) begin
      m_addr[i] = '0; m_pass[i] = 0; m_en[i] = 0;
    end
  endtask

  task automatic model_edge();
    int prev;
    int w;
    prev = m_st;
    if (start) begin
      m_st = M_RUN; m_cnt = 0; m_hit = 0; m_run = 0;
    end else if (m_st == M_RUN) begin
      w = -1;
      for (int i = 0; i < NW; i++)
        if (w < 0 && m_en[i] && pc_valid && pc == m_addr[i]) w = i;
      if (pc_valid) begin
        m_run  = (m_run > 0 && pc == m_last) ? m_run + 1 : 1;
        m_last = pc;
      end else begin
        m_run = 0;
      end
      if (w >= 0) begin
        m_st  = m_pass[w] ? M_PASS : M_FAIL;
        m_hit = w;
      end else begin
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (timeout_limit != 0 && m_cnt == int'(timeout_limit)) m_st = M_TO;
`ifdef TESTMON_STALL_EN
        else if (m_run >= SL) begin
          m_st  = M_FAIL;
          m_hit = NW - 1;
        end
`endif
      end
    end
    if (cfg_wen && prev != M_RUN && int'(cfg_idx) < NW) begin
      m_addr[cfg_idx] = cfg_addr;
      m_pass[cfg_idx] = cfg_is_pass;
      m_en[cfg_idx]   = cfg_en;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".busy"},      busy,        m_st == M_RUN);
    check({tag, ".done"},      done,        m_st >= M_PASS);
    check({tag, ".passed"},    passed,      m_st == M_PASS);
    check({tag, ".failed"},    failed,      m_st == M_FAIL);
    check({tag, ".timed_out"}, timed_out,   m_st == M_TO);
    check({tag, ".hit_idx"},   hit_idx,     m_hit);
    check({tag, ".cycles"},    cycle_count, m_cnt);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic wr(input int idx, input logic [XLEN-1:0] a, input bit ps, input bit en);
    cfg_wen = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_is_pass = ps; cfg_en = en;
    cyc("cfg");
    cfg_wen = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc("start");
    start = 1'b0;
  endtask

  logic [XLEN-1:0] pool [8];
  int first_to;

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    check("reset.busy_const", busy, 1'b0);

    // start held through reset must not launch a run until rst_n releases
    start = 1'b1;
    cyc("rst_start");
    cyc("rst_start");
    check("rst_start.idle", busy, 1'b0);
    rst_n = 1'b1;
    timeout_limit = 10'd5;
    cyc("first_start");
    start = 1'b0;
    check("first_start.busy", busy, 1'b1);
    repeat (5) cyc("short_to");
    check("short_to.timed_out", timed_out, 1'b1);

    // pass hit on an incrementing pc stream
    timeout_limit = '0;
    wr(0, 32'h8000_0040, 1'b1, 1'b1);
    wr(1, 32'h8000_0050, 1'b0, 1'b1);
    go();
    pc_valid = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      pc = 32'h8000_0000 + 32'(4 * k);
      cyc("pass_run");
    end
    pc_valid = 1'b0;
    check("pass.passed", passed, 1'b1);
    check("pass.hit_idx", hit_idx, 2'd0);
    repeat (3) begin pc = 32'h8000_0050; pc_valid = 1'b1; cyc("pass_hold"); end
    check("pass.held", passed, 1'b1);

    // fail hit in run cycle 7
    go();
    pc_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pc = 32'h0000_1000 + 32'(4 * k);
      cyc("fail_run");
    end
    pc = 32'h8000_0050;
    cyc("fail_hit");
    pc_valid = 1'b0;
    check("fail.failed", failed, 1'b1);
    check("fail.hit_idx", hit_idx, 2'd1);
    check("fail.cycles", cycle_count, 10'd7);

    // timeout of 1000 with no matching pc
    timeout_limit = 10'd1000;
    go();
    first_to = 0;
    for (int k = 1; k <= 1100 && first_to == 0; k++) begin
      cyc("to_run");
      if (timed_out) first_to = k;
    end
    check("to.latency", first_to, 1000);
    check("to.cycles", cycle_count, 10'd1000);

    // overlapping entries: lowest index wins
    timeout_limit = '0;
    wr(2, 32'h100, 1'b0, 1'b1);
    wr(3, 32'h100, 1'b1, 1'b1);
    go();
    pc = 32'h100; pc_valid = 1'b1;
    cyc("overlap");
    pc_valid = 1'b0;
    check("overlap.failed", failed, 1'b1);
    check("overlap.hit_idx", hit_idx, 2'd2);

    // reset mid-run wipes outputs and the watch table
    go();
    repeat (3) cyc("pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("midrst");
    check("midrst.busy", busy, 1'b0);
    check("midrst.cycles", cycle_count, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    timeout_limit = 10'd50;
    pc_valid = 1'b1;
    pc = 32'h8000_0040;
    go();
    for (int k = 0; k < 50; k++) begin
      pc = k[0] ? 32'h8000_0050 : 32'h8000_0040;
      cyc("post_rst");
    end
    pc_valid = 1'b0;
    check("post_rst.timed_out", timed_out, 1'b1);
    check("post_rst.passed", passed, 1'b0);

    // self-looping pc
    timeout_limit = '0;
    go();
    pc = 32'h200; pc_valid = 1'b1;
    repeat (SL - 1) cyc("stall");
    check("stall.before_limit", busy, 1'b1);
    cyc("stall");
`ifdef TESTMON_STALL_EN
    check("stall.failed", failed, 1'b1);
    check("stall.hit_idx", hit_idx, 2'd3);
`else
    repeat (24) cyc("stall");
    check("stall.still_busy", busy, 1'b1);
`endif
    pc_valid = 1'b0;

    // counter saturates at all-ones
    go();
    repeat (CMAX + 8) cyc("sat");
    check("sat.cycles", cycle_count, 10'h3FF);
    check("sat.busy", busy, 1'b1);

    // randomized traffic
    pool[0] = 32'h100;        pool[1] = 32'h200;        pool[2] = 32'h8000_0040; pool[3] = 32'h8000_0050;
    pool[4] = 32'h0000_0300;  pool[5] = 32'h0000_0400;  pool[6] = 32'hDEAD_0000; pool[7] = 32'h0;
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 39) == 0);
      if (start) timeout_limit = CW'($urandom_range(0, 60));
      cfg_wen     = ($urandom_range(0, 7) == 0);
      cfg_idx     = 2'($urandom_range(0, 3));
      cfg_addr    = pool[$urandom_range(0, 7)];
      cfg_is_pass = 1'($urandom_range(0, 1));
      cfg_en      = ($urandom_range(0, 3) != 0);
      pc_valid    = ($urandom_range(0, 3) != 0);
      pc          = ($urandom_range(0, 5) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)];
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/test_status_monitor.md
TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of the monitored PC and of the watch addresses.
REQ-002 The block SHALL have parameter NUM_WATCH, default 4 (min 1): number of programmable watch-address entries.
REQ-003 The block SHALL have parameter CNT_W, default 32: width of the cycle counter and of the timeout limit.
REQ-004 The block SHALL have parameter STALL_LIMIT, default 16: consecutive same-PC valid cycles that count as a stall, used only under TESTMON_STALL_EN.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-008 The block SHALL have ports cfg_wen (1 bit), cfg_idx ($clog2(NUM_WATCH) bits, min 1), cfg_addr (XLEN bits), cfg_is_pass (1 bit) and cfg_en (1 bit), all inputs: watch-entry write.
REQ-009 The block SHALL have port timeout_limit, input, CNT_W bits: run-cycle limit; 0 disables the timeout.
REQ-010 The block SHALL have ports pc (input, XLEN bits) and pc_valid (input, 1 bit): the retiring PC sample.
REQ-011 The block SHALL have outputs busy, done, passed, failed and timed_out, each 1 bit: run status.
REQ-012 The block SHALL have outputs hit_idx ($clog2(NUM_WATCH) bits, min 1) and cycle_count (CNT_W bits).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN, PASS, FAIL and TIMEOUT; busy SHALL be 1 only in RUN, and done SHALL be 1 in PASS, FAIL and TIMEOUT.
REQ-014 passed, failed and timed_out SHALL be 1 exactly in PASS, FAIL and TIMEOUT respectively; all outputs SHALL be registered.
REQ-015 Each watch entry SHALL hold addr, is_pass and en; a cfg_wen write to entry cfg_idx SHALL take effect at the next edge; a cfg_idx >= NUM_WATCH SHALL be ignored.
REQ-016 cfg_wen SHALL be ignored while in RUN.
REQ-017 When start=1 in any state other than under reset, the FSM SHALL enter RUN next cycle, clearing cycle_count to 0 and hit_idx to 0; start in RUN SHALL restart the run.
REQ-018 In RUN, a hit SHALL occur when pc_valid=1 and pc equals the addr of an entry with en=1.
REQ-019 On a hit the FSM SHALL go to PASS if the matching entry's is_pass=1, otherwise to FAIL, with hit_idx set to that entry; status SHALL be visible the cycle after the matching sample.
REQ-020 When several entries match, the lowest index SHALL win.
REQ-021 In RUN, each cycle without a hit SHALL increment cycle_count; if timeout_limit != 0 and the incremented value equals timeout_limit, the FSM SHALL enter TIMEOUT.
REQ-022 With timeout_limit=1000, timed_out SHALL rise exactly 1000 cycles after the start edge.
REQ-023 A hit and a timeout in the same cycle SHALL resolve to the hit.
REQ-024 cycle_count SHALL saturate at all-ones and SHALL hold its value in IDLE and in the terminal states.
REQ-025 Terminal states SHALL persist until start or reset; pc activity in IDLE or terminal states SHALL be ignored.

Reset
REQ-026 While rst_n=0 the block SHALL asynchronously force: state IDLE, busy/done/passed/failed/timed_out 0, hit_idx 0, cycle_count 0, every entry en=0, addr=0, is_pass=0.
REQ-027 Reset asserted mid-RUN SHALL abort the run immediately; start SHALL be honoured only on the first edge after rst_n deasserts, not during reset.

Configuration
REQ-028 With TESTMON_STALL_EN defined, RUN SHALL track consecutive pc_valid cycles that carry the same pc; when that count reaches STALL_LIMIT without a hit, the FSM SHALL enter FAIL with hit_idx all-ones; a hit SHALL take priority over a stall and timeout SHALL take priority over a stall.
REQ-029 With TESTMON_STALL_EN undefined, the block SHALL have no stall logic, and a self-looping PC SHALL end the run only by hit or timeout.

Verification
REQ-030 The bench SHALL cover: entry0={0x80000040, pass, en}, entry1={0x80000050, fail, en}, start, pc_valid stream reaching 0x80000040 -> passed=1, hit_idx=0 the next cycle.
REQ-031 The bench SHALL cover: same configuration, pc reaching 0x80000050 at run cycle 7 -> failed=1, hit_idx=1, cycle_count=7.
REQ-032 The bench SHALL cover: timeout_limit=1000, no matching pc -> timed_out=1 exactly 1000 cycles after start, cycle_count=1000.
REQ-033 The bench SHALL cover: entries 2 and 3 both at 0x100 with entry2=fail and entry3=pass, pc=0x100 -> failed=1, hit_idx=2.
REQ-034 The bench SHALL cover: rst_n=0 pulse during RUN -> all outputs 0 and all entries disabled; a following start with pc=0x80000040 -> no hit and eventual timed_out.
REQ-035 The bench SHALL cover: with TESTMON_STALL_EN, STALL_LIMIT=16, pc held at 0x200 with pc_valid=1 -> failed=1, hit_idx all-ones after 16 samples; without the macro -> still busy.
